// File: rtl/pipelined_execute_unit.sv
// Execute stage: ALU, load/store address generation, beq/bne/j resolution and
// an optional iterative mul/div engine with HI/LO (build macro EXEC_MULDIV_EN).
module pipelined_execute_unit #(
  parameter int WIDTH    = 32,
  parameter int PC_WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic [31:0]         inst,
  input  logic [WIDTH-1:0]    oprand1,
  input  logic [WIDTH-1:0]    oprand2,
  input  logic [WIDTH-1:0]    to_mem1,
  input  logic [PC_WIDTH-1:0] pc_count,
  input  logic                pre_target_enable,
  output logic [31:0]         inst2,
  output logic [WIDTH-1:0]    result,
  output logic [WIDTH-1:0]    to_mem2,
  output logic [PC_WIDTH-1:0] target,
  output logic                target_enable,
  output logic                true_taken,
  output logic [31:0]         mod_inst,
  output logic [PC_WIDTH-1:0] mod_pc,
  output logic                busy
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  logic [5:0] op, fn;
  logic       is_rtype, accept;
  assign op       = inst[31:26];
  assign fn       = inst[5:0];
  assign is_rtype = (op == OP_RTYPE);
  assign accept   = !stall && !busy;

  logic [WIDTH-1:0] alu_res, md_res, result_d;
  logic             md_read;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    alu_res = '0;
    if (is_rtype) begin
      case (fn)
        FN_ADD, FN_ADDU: alu_res = oprand1 + oprand2;
        FN_SUB, FN_SUBU: alu_res = oprand1 - oprand2;
        FN_AND:          alu_res = oprand1 & oprand2;
        FN_OR:           alu_res = oprand1 | oprand2;
        FN_XOR:          alu_res = oprand1 ^ oprand2;
        FN_SLT:          alu_res = WIDTH'($signed(oprand1) < $signed(oprand2));
        FN_SLL:          alu_res = oprand2 << inst[10:6];
        default:         alu_res = '0;
      endcase
    end else begin
      case (op)
        OP_ADDI, OP_LW, OP_SW: alu_res = oprand1 + oprand2;
        OP_LUI:                alu_res = oprand2 << 16;
        default:               alu_res = '0;
      endcase
    end
  end

  assign result_d = md_read ? md_res : alu_res;

  // Branch resolution
  logic                is_beq, is_bne, is_j, is_branch, taken;
  logic [PC_WIDTH-1:0] seq_pc, br_target, j_target, next_target;
  assign is_beq      = (op == OP_BEQ);
  assign is_bne      = (op == OP_BNE);
  assign is_j        = (op == OP_J);
  assign is_branch   = is_beq || is_bne || is_j;
  assign taken       = (is_beq && (oprand1 == oprand2)) ||
                       (is_bne && (oprand1 != oprand2)) || is_j;
  assign seq_pc      = pc_count + PC_WIDTH'(4);
  assign br_target   = seq_pc + {{(PC_WIDTH-18){inst[15]}}, inst[15:0], 2'b00};
  assign j_target    = (pc_count & ~PC_WIDTH'(28'hFFF_FFFF)) | PC_WIDTH'({inst[25:0], 2'b00});
  assign next_target = taken ? (is_j ? j_target : br_target) : seq_pc;

`ifdef EXEC_MULDIV_EN
  localparam logic [5:0] FN_MFHI = 6'b010000;
  localparam logic [5:0] FN_MFLO = 6'b010010;
  localparam int         CNT_W   = $clog2(WIDTH + 1);
  localparam logic       IDLE    = 1'b0;
  localparam logic       RUN     = 1'b1;

  logic               state_q, div_q, neg_q, rneg_q, dz_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   hi_q, lo_q, a_q, w_hi_q, w_lo_q;
  logic               is_md_op, s1, s2, md_issue, last_step, div_ge;
  logic [WIDTH-1:0]   mag1, mag2, div_diff, step_hi, step_lo, fin_hi, fin_lo;
  logic [WIDTH:0]     mul_sum, div_shift;
  logic [2*WIDTH-1:0] prod;

  assign is_md_op  = is_rtype && (fn[5:2] == 4'b0110);  // mult, multu, div, divu
  assign md_read   = is_rtype && (fn == FN_MFHI || fn == FN_MFLO);
  assign md_res    = (fn == FN_MFHI) ? hi_q : lo_q;
  assign busy      = (state_q == RUN) && (is_md_op || md_read);
  assign s1        = !fn[0] && oprand1[WIDTH-1];
  assign s2        = !fn[0] && oprand2[WIDTH-1];
  assign mag1      = s1 ? -oprand1 : oprand1;
  assign mag2      = s2 ? -oprand2 : oprand2;
  assign md_issue  = accept && is_md_op;
  assign last_step = (cnt_q == CNT_W'(1));

  // One shift-add (mult) or restoring-subtract (div) step on magnitudes per edge.
  always_comb begin
    mul_sum   = {1'b0, w_hi_q} + (w_lo_q[0] ? {1'b0, a_q} : '0);
    div_shift = {w_hi_q, w_lo_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, a_q});
    div_diff  = div_shift[WIDTH-1:0] - a_q;
    if (div_q) begin
      step_hi = div_ge ? div_diff : div_shift[WIDTH-1:0];
      step_lo = {w_lo_q[WIDTH-2:0], div_ge};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], w_lo_q[WIDTH-1:1]};
    end
    prod = neg_q ? -{step_hi, step_lo} : {step_hi, step_lo};
    if (dz_q) begin
      fin_hi = w_lo_q;
      fin_lo = '1;
    end else if (div_q) begin
      fin_hi = rneg_q ? -step_hi : step_hi;
      fin_lo = neg_q ? -step_lo : step_lo;
    end else begin
      {fin_hi, fin_lo} = prod;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else if (md_issue) begin
      state_q <= RUN;
      cnt_q   <= CNT_W'(WIDTH);
    end else if (state_q == RUN) begin
      cnt_q <= cnt_q - CNT_W'(1);
      if (last_step) begin
        state_q <= IDLE;
        hi_q    <= fin_hi;
        lo_q    <= fin_lo;
      end
    end
  end

  // NOTE: work registers are always loaded at issue before use, so they carry no reset.
  always_ff @(posedge clk) begin
    if (md_issue) begin
      div_q  <= fn[1];
      neg_q  <= s1 ^ s2;
      rneg_q <= s1;
      dz_q   <= fn[1] && (oprand2 == '0);
      w_hi_q <= '0;
      if (fn[1]) begin
        a_q    <= mag2;
        w_lo_q <= (oprand2 == '0) ? oprand1 : mag1;
      end else begin
        a_q    <= mag1;
        w_lo_q <= mag2;
      end
    end else if (state_q == RUN && !dz_q) begin
      w_hi_q <= step_hi;
      w_lo_q <= step_lo;
    end
  end
`else
  assign busy    = 1'b0;
  assign md_read = 1'b0;
  assign md_res  = '0;
`endif

  logic [31:0]         inst2_q, mod_inst_q;
  logic [WIDTH-1:0]    result_q, to_mem2_q;
  logic [PC_WIDTH-1:0] target_q, mod_pc_q;
  logic                target_enable_q, true_taken_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      inst2_q         <= '0;
      result_q        <= '0;
      to_mem2_q       <= '0;
      target_q        <= '0;
      target_enable_q <= 1'b0;
      true_taken_q    <= 1'b0;
      mod_inst_q      <= '0;
      mod_pc_q        <= '0;
    end else begin
      // Redirect is a pulse: it clears on any cycle without a mispredicted acceptance.
      target_enable_q <= accept && is_branch && (taken != pre_target_enable);
      if (!stall) begin
        if (busy) begin
          inst2_q   <= '0;
          result_q  <= '0;
          to_mem2_q <= '0;
        end else begin
          inst2_q   <= inst;
          result_q  <= result_d;
          to_mem2_q <= to_mem1;
          if (is_branch) begin
            true_taken_q <= taken;
            target_q     <= next_target;
            mod_inst_q   <= inst;
            mod_pc_q     <= pc_count;
          end
        end
      end
    end
  end

  assign inst2         = inst2_q;
  assign result        = result_q;
  assign to_mem2       = to_mem2_q;
  assign target        = target_q;
  assign target_enable = target_enable_q;
  assign true_taken    = true_taken_q;
  assign mod_inst      = mod_inst_q;
  assign mod_pc        = mod_pc_q;

endmodule

// File: tb/tb_pipelined_execute_unit.sv
// Directed bench for pipelined_execute_unit; mul/div checks follow EXEC_MULDIV_EN.
module tb_pipelined_execute_unit;
  localparam int W  = 32;
  localparam int PW = 32;

  localparam logic [5:0] FN_SLL = 6'b000000, FN_ADD = 6'b100000, FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB = 6'b100010, FN_AND = 6'b100100, FN_OR = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110, FN_SLT = 6'b101010;
  localparam logic [5:0] FN_MULT = 6'b011000, FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV = 6'b011010, FN_DIVU = 6'b011011;
  localparam logic [5:0] FN_MFHI = 6'b010000, FN_MFLO = 6'b010010;
  localparam logic [5:0] OP_ADDI = 6'b001000, OP_LUI = 6'b001111, OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011, OP_BEQ = 6'b000100, OP_BNE = 6'b000101;

  logic          clk = 1'b0;
  logic          reset, stall, pre_target_enable;
  logic [31:0]   inst;
  logic [W-1:0]  oprand1, oprand2, to_mem1;
  logic [PW-1:0] pc_count;
  logic [31:0]   inst2, mod_inst;
  logic [W-1:0]  result, to_mem2;
  logic [PW-1:0] target, mod_pc;
  logic          target_enable, true_taken, busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pipelined_execute_unit #(.WIDTH(W), .PC_WIDTH(PW)) dut (
    .clk(clk), .reset(reset), .stall(stall), .inst(inst),
    .oprand1(oprand1), .oprand2(oprand2), .to_mem1(to_mem1),
    .pc_count(pc_count), .pre_target_enable(pre_target_enable),
    .inst2(inst2), .result(result), .to_mem2(to_mem2), .target(target),
    .target_enable(target_enable), .true_taken(true_taken),
    .mod_inst(mod_inst), .mod_pc(mod_pc), .busy(busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] r_op(input logic [5:0] fn);
    return {26'b0, fn};
  endfunction

  function automatic logic [31:0] i_op(input logic [5:0] op, input logic [15:0] imm);
    return {op, 5'd1, 5'd2, imm};
  endfunction

  task automatic alu_vec(input string tag, input logic [31:0] i, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] exp);
    inst = i; oprand1 = a; oprand2 = b;
    tick();
    check({tag, "/result"}, result, exp);
    check({tag, "/inst2"}, inst2, i);
  endtask

  task automatic br_vec(input string tag, input logic [31:0] i, input logic [PW-1:0] pc,
                        input logic [W-1:0] a, input logic [W-1:0] b, input logic pre,
                        input logic exp_taken, input logic [PW-1:0] exp_tgt, input logic exp_te);
    inst = i; pc_count = pc; oprand1 = a; oprand2 = b; pre_target_enable = pre;
    tick();
    check({tag, "/true_taken"}, true_taken, exp_taken);
    check({tag, "/target"}, target, exp_tgt);
    check({tag, "/target_enable"}, target_enable, exp_te);
    check({tag, "/mod_pc"}, mod_pc, pc);
    check({tag, "/mod_inst"}, mod_inst, i);
    inst = r_op(FN_ADD); pc_count = pc + 32'h40; pre_target_enable = 1'b0;
    tick();
    check({tag, "/te_pulse_end"}, target_enable, 1'b0);
    check({tag, "/target_held"}, target, exp_tgt);
    check({tag, "/mod_pc_held"}, mod_pc, pc);
  endtask

`ifdef EXEC_MULDIV_EN
  task automatic md_run(input string tag, input logic [5:0] fn, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp_hi,
                        input logic [W-1:0] exp_lo);
    int n;
    inst = r_op(fn); oprand1 = a; oprand2 = b;
    tick();
    check({tag, "/issue_result"}, result, '0);
    check({tag, "/issue_inst2"}, inst2, r_op(fn));
    inst = r_op(FN_MFHI);
    n = 0;
    while (busy && n < 100) begin
      n++;
      tick();
    end
    check({tag, "/busy_cycles"}, n, W);
    check({tag, "/bubble_inst2"}, inst2, '0);
    tick();
    check({tag, "/hi"}, result, exp_hi);
    inst = r_op(FN_MFLO);
    tick();
    check({tag, "/lo"}, result, exp_lo);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; stall = 1'b0; pre_target_enable = 1'b0;
    inst = '0; oprand1 = '0; oprand2 = '0; to_mem1 = '0; pc_count = '0;
    tick();
    tick();
    check("rst/result", result, '0);
    check("rst/inst2", inst2, '0);
    check("rst/target", target, '0);
    check("rst/target_enable", target_enable, 1'b0);
    check("rst/mod_pc", mod_pc, '0);
    check("rst/busy", busy, 1'b0);
    reset = 1'b0;

    // add with wrap, then hold under stall while inputs change
    to_mem1 = 32'h55;
    alu_vec("add_wrap", r_op(FN_ADD), 32'd7, 32'hFFFF_FFFF, 32'd6);
    check("add/to_mem2", to_mem2, 32'h55);
    stall = 1'b1;
    inst = r_op(FN_SUB); oprand1 = 32'd100; oprand2 = 32'd1; to_mem1 = 32'h99;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stall/result", result, 32'd6);
      check("stall/inst2", inst2, r_op(FN_ADD));
      check("stall/to_mem2", to_mem2, 32'h55);
    end
    stall = 1'b0;

    alu_vec("sub", r_op(FN_SUB), 32'd5, 32'd7, 32'hFFFF_FFFE);
    alu_vec("addu_ovf", r_op(FN_ADDU), 32'h8000_0000, 32'h8000_0000, 32'h0);
    alu_vec("and", r_op(FN_AND), 32'hF0F0, 32'hFF00, 32'hF000);
    alu_vec("or", r_op(FN_OR), 32'hF0F0, 32'hFF00, 32'hFFF0);
    alu_vec("xor", r_op(FN_XOR), 32'hF0F0, 32'hFF00, 32'h0FF0);
    alu_vec("slt_true", r_op(FN_SLT), 32'hFFFF_FFFF, 32'd1, 32'd1);
    alu_vec("slt_false", r_op(FN_SLT), 32'd1, 32'hFFFF_FFFF, 32'd0);
    alu_vec("sll4", {21'b0, 5'd4, FN_SLL}, 32'hDEAD, 32'h1234, 32'h0001_2340);
    alu_vec("lui", i_op(OP_LUI, 16'h1234), 32'hDEAD, 32'h1234, 32'h1234_0000);
    alu_vec("addi_neg", i_op(OP_ADDI, 16'hFFFC), 32'h10, 32'hFFFF_FFFC, 32'hC);
    alu_vec("lw", i_op(OP_LW, 16'h8), 32'h1000, 32'h8, 32'h1008);
    to_mem1 = 32'hDEAD_BEEF;
    alu_vec("sw", i_op(OP_SW, 16'h4), 32'h2000, 32'h4, 32'h2004);
    check("sw/to_mem2", to_mem2, 32'hDEAD_BEEF);
    alu_vec("unlisted_op", {6'b111111, 26'h3FF_FFFF}, 32'd3, 32'd4, 32'h0);
    alu_vec("unlisted_fn", r_op(6'b111111), 32'd3, 32'd4, 32'h0);

    br_vec("beq_taken", i_op(OP_BEQ, 16'h0004), 32'h100, 32'd9, 32'd9, 1'b0, 1'b1, 32'h114, 1'b1);
    br_vec("beq_predicted", i_op(OP_BEQ, 16'h0004), 32'h100, 32'd9, 32'd9, 1'b1, 1'b1, 32'h114, 1'b0);
    br_vec("beq_not_taken", i_op(OP_BEQ, 16'h0004), 32'h100, 32'd1, 32'd2, 1'b0, 1'b0, 32'h104, 1'b0);
    br_vec("bne_equal", i_op(OP_BNE, 16'h0004), 32'h100, 32'd5, 32'd5, 1'b1, 1'b0, 32'h104, 1'b1);
    br_vec("beq_backward", i_op(OP_BEQ, 16'hFFFF), 32'h200, 32'd0, 32'd0, 1'b1, 1'b1, 32'h200, 1'b0);
    br_vec("j_region", {6'b000010, 26'h123456}, 32'hF000_0100, 32'd0, 32'd1, 1'b0, 1'b1,
           32'hF048_D158, 1'b1);

`ifdef EXEC_MULDIV_EN
    md_run("mult_neg", FN_MULT, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    md_run("multu", FN_MULTU, 32'hFFFF_FFFF, 32'd2, 32'h1, 32'hFFFF_FFFE);
    md_run("mult_m3x5", FN_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    md_run("div_m7_2", FN_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    md_run("divu_100_7", FN_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    md_run("divu_by0", FN_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
    md_run("div_min_m1", FN_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);

    // Independent work overlaps RUN; reset then aborts the operation
    inst = r_op(FN_MULT); oprand1 = 32'd3; oprand2 = 32'd5;
    tick();
    inst = i_op(OP_ADDI, 16'h2); oprand1 = 32'd1; oprand2 = 32'd2;
    check("run_addi/busy", busy, 1'b0);
    tick();
    check("run_addi/result", result, 32'd3);
    check("run_addi/inst2", inst2, i_op(OP_ADDI, 16'h2));
    inst = r_op(FN_MFLO);
    check("run_mflo/busy", busy, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_run/result", result, '0);
    check("rst_run/inst2", inst2, '0);
    check("rst_run/busy", busy, 1'b0);
    tick();
    check("rst_run/mflo", result, '0);
    inst = r_op(FN_MFHI);
    tick();
    check("rst_run/mfhi", result, '0);
`else
    begin
      logic seen_busy;
      inst = r_op(FN_MULT); oprand1 = 32'hFFFF_FFFF; oprand2 = 32'd2;
      check("nomd/busy_issue", busy, 1'b0);
      tick();
      check("nomd/mult_result", result, '0);
      check("nomd/mult_inst2", inst2, r_op(FN_MULT));
      inst = r_op(FN_MFHI);
      seen_busy = 1'b0;
      for (int k = 0; k < 40; k++) begin
        seen_busy = seen_busy | busy;
        tick();
      end
      check("nomd/busy_ever", seen_busy, 1'b0);
      check("nomd/mfhi_result", result, '0);
      check("nomd/mfhi_inst2", inst2, r_op(FN_MFHI));
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
